// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO read-side unpacker: ratio/width math, the lane
// index type and the lane extraction function.
package fifo_pkg;

    // Widest word the lane selector handles.
    localparam int unsigned MAX_W = 512;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned calc_ratio(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    localparam int unsigned LANE_IDX_W = idx_width(MAX_W);

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Returns the selected lane in the low out_w bits; callers truncate to their beat width.
    function automatic logic [MAX_W-1:0] lane_sel(
        input logic [MAX_W-1:0] word,
        input lane_idx_t        idx,
        input int unsigned      out_w,
        input int unsigned      ratio,
        input logic             lsb_first
    );
        int unsigned lane;
        lane = lsb_first ? 32'(idx) : (ratio - 32'd1 - 32'(idx));
        return word >> (lane * out_w);
    endfunction

endpackage

// File: rtl/fifo_rd_unpack.sv
// Pops 64-bit words from a non-FWFT FIFO read port and serialises each into
// RATIO narrow beats on a valid/ready stream with burst framing.
module fifo_rd_unpack
    import fifo_pkg::*;
#(
    parameter int unsigned IN_W        = 64,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned LSB_FIRST   = 1,
    parameter int unsigned BURST_BEATS = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             fifo_rd_en,
    input  logic [IN_W-1:0]  fifo_rd_data,
    input  logic             fifo_rd_empty,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam int unsigned      RATIO     = calc_ratio(IN_W, OUT_W);
    localparam lane_idx_t        LAST_LANE = lane_idx_t'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_BEATS - 1);

    logic [IN_W-1:0]  cur_q, cur_d;
    logic             cur_v_q, cur_v_d;
    logic [IN_W-1:0]  nxt_q, nxt_d;
    logic             nxt_v_q, nxt_v_d;
    logic             pend_q, pend_d;
    lane_idx_t        lane_q, lane_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rd_en;
    logic hs;
    logic last_hs;
    logic cur_free;

    always_comb begin
        // rst_n gates the read so no word is popped and lost while state is held in reset.
        rd_en    = rst_n && !fifo_rd_empty && !pend_q && !nxt_v_q && !flush;
        hs       = cur_v_q && out_ready;
        last_hs  = hs && (lane_q == LAST_LANE);
        cur_free = !cur_v_q || last_hs;

        cur_d   = cur_q;
        cur_v_d = cur_v_q;
        nxt_d   = nxt_q;
        nxt_v_d = nxt_v_q;
        pend_d  = rd_en;
        lane_d  = lane_q;
        cnt_d   = cnt_q;

        if (hs) begin
            lane_d = last_hs ? '0 : lane_q + lane_idx_t'(1);
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        if (last_hs) begin
            if (nxt_v_q) begin
                cur_d   = nxt_q;
                cur_v_d = 1'b1;
                nxt_v_d = 1'b0;
            end else begin
                cur_v_d = 1'b0;
            end
        end

        // A read is only issued with nxt empty, so pend and nxt_v are never both set.
        if (pend_q) begin
            if (cur_free) begin
                cur_d   = fifo_rd_data;
                cur_v_d = 1'b1;
            end else begin
                nxt_d   = fifo_rd_data;
                nxt_v_d = 1'b1;
            end
        end

        if (flush) begin
            cur_v_d = 1'b0;
            nxt_v_d = 1'b0;
            pend_d  = 1'b0;
            lane_d  = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q   <= '0;
            cur_v_q <= 1'b0;
            nxt_q   <= '0;
            nxt_v_q <= 1'b0;
            pend_q  <= 1'b0;
            lane_q  <= '0;
            cnt_q   <= '0;
        end else begin
            cur_q   <= cur_d;
            cur_v_q <= cur_v_d;
            nxt_q   <= nxt_d;
            nxt_v_q <= nxt_v_d;
            pend_q  <= pend_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign out_valid  = cur_v_q;
    assign out_data   = OUT_W'(lane_sel(MAX_W'(cur_q), lane_q, OUT_W, RATIO, LSB_FIRST != 0));
    assign out_last   = cur_v_q && (cnt_q == CNT_LAST);
    assign beat_cnt   = cnt_q;

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Directed bench for fifo_rd_unpack: LSB-first unit with 6-beat bursts plus an
// MSB-first unit with single-beat bursts, each fed by a small FIFO model.
module tb_fifo_rd_unpack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, flush1;
    logic out_ready, ready1;

    logic [1:0]  rd_en;
    logic [1:0]  empty;
    logic [63:0] rd_data [2];
    logic [63:0] fmem [2][64];
    int unsigned wp [2] = '{0, 0};
    int unsigned rp [2] = '{0, 0};

    logic        out_valid, out_last;
    logic [15:0] out_data, beat_cnt;
    logic        v1, l1;
    logic [15:0] d1, c1;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    fifo_rd_unpack #(.IN_W(64), .OUT_W(16), .LSB_FIRST(1), .BURST_BEATS(6), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]), .fifo_rd_empty(empty[0]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .beat_cnt(beat_cnt)
    );

    fifo_rd_unpack #(.IN_W(64), .OUT_W(16), .LSB_FIRST(0), .BURST_BEATS(1), .CNT_W(16)) dut_msb (
        .clk(clk), .rst_n(rst_n), .flush(flush1),
        .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]), .fifo_rd_empty(empty[1]),
        .out_valid(v1), .out_ready(ready1), .out_data(d1),
        .out_last(l1), .beat_cnt(c1)
    );

    // Non-FWFT FIFO model: data appears one clock after the read enable.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
                rd_data[i] <= fmem[i][rp[i] % 64];
                rp[i]      <= rp[i] + 1;
            end
        end
    end
    assign empty[0] = (wp[0] == rp[0]);
    assign empty[1] = (wp[1] == rp[1]);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int unsigned inst, input logic [63:0] w);
        fmem[inst][wp[inst] % 64] = w;
        wp[inst] = wp[inst] + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mkword(input logic [15:0] base);
        return {base + 16'd3, base + 16'd2, base + 16'd1, base};
    endfunction

    // Monitor for the LSB-first unit: beat log, stall stability, read-issue rules.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] log_d [$];
    logic        log_l [$];
    logic [15:0] log_c [$];
    int unsigned log_t [$];
    int unsigned rd_pulses = 0;
    int          in_flight = 0;
    int unsigned beat_mod  = 0;
    logic        prev_rd = 1'b0, prev_stall = 1'b0, prev_l = 1'b0;
    logic [15:0] prev_d = '0, prev_c = '0;

    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (prev_rd)        check("rd_while_pend", 64'(rd_en[0]), 64'd0);
            if (in_flight >= 2) check("rd_while_full", 64'(rd_en[0]), 64'd0);
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_d));
                check("stall_last", 64'(out_last), 64'(prev_l));
                check("stall_cnt", 64'(beat_cnt), 64'(prev_c));
            end
            if (rd_en[0]) begin
                rd_pulses++;
                in_flight++;
            end
            if (out_valid && out_ready) begin
                log_d.push_back(out_data);
                log_l.push_back(out_last);
                log_c.push_back(beat_cnt);
                log_t.push_back(cyc);
                beat_mod = (beat_mod + 1) % 4;
                if (beat_mod == 0) in_flight--;
            end
        end else begin
            if (rst_n && flush) check("rd_in_flush", 64'(rd_en[0]), 64'd0);
            in_flight = 0;
            beat_mod  = 0;
        end
        prev_rd    = rd_en[0];
        prev_stall = rst_n && !flush && out_valid && !out_ready;
        prev_d     = out_data;
        prev_l     = out_last;
        prev_c     = beat_cnt;
    end

    task automatic clear_log();
        log_d.delete();
        log_l.delete();
        log_c.delete();
        log_t.delete();
    endtask

    task automatic wait_beats(input string tag, input int unsigned n, input int unsigned budget);
        int unsigned k;
        k = 0;
        while (log_d.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (log_d.size() < n) check({tag, "_timeout"}, 64'(log_d.size()), 64'(n));
    endtask

    logic [15:0] t1_exp [4]  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] msb_exp [8] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD,
                                 16'h1111, 16'h2222, 16'h3333, 16'h4444};

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        flush1    = 1'b0;
        out_ready = 1'b1;
        ready1    = 1'b1;

        // Reset and basic unpack
        tick();
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_cnt", 64'(beat_cnt), 64'd0);
        check("rst_valid_msb", 64'(v1), 64'd0);
        tick();
        push(0, 64'h4444_3333_2222_1111);
        @(negedge clk);
        check("rst_rd_gate", 64'(rd_en[0]), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_rd_en", 64'(rd_en[0]), 64'd1);
        check("t1_valid_c0", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t1_rd_en_c1", 64'(rd_en[0]), 64'd0);
        check("t1_valid_c1", 64'(out_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_data", 64'(out_data), 64'(t1_exp[k]));
            check("t1_cnt", 64'(beat_cnt), 64'(k));
            check("t1_last", 64'(out_last), 64'd0);
        end
        tick();
        @(negedge clk);
        check("t1_valid_end", 64'(out_valid), 64'd0);
        check("t1_cnt_kept", 64'(beat_cnt), 64'd4);

        // Framing: flush clears the counter and blocks the read while words wait
        tick();
        push(0, mkword(16'h0A00));
        push(0, mkword(16'h0A04));
        push(0, mkword(16'h0A08));
        flush = 1'b1;
        clear_log();
        tick();
        flush = 1'b0;
        wait_beats("frame", 12, 60);
        for (int n = 0; n < 12 && n < log_d.size(); n++) begin
            check("frame_data", 64'(log_d[n]), 64'(16'h0A00 + 16'(n)));
            check("frame_cnt", 64'(log_c[n]), 64'(n % 6));
            check("frame_last", 64'(log_l[n]), 64'((n % 6) == 5));
        end

        // Streaming: 8 preloaded words, 32 back-to-back beats
        clear_log();
        rd_pulses = 0;
        for (int w = 0; w < 8; w++) push(0, mkword(16'h5000 + 16'(4 * w)));
        wait_beats("stream", 32, 100);
        repeat (4) tick();
        check("stream_beats", 64'(log_d.size()), 64'd32);
        check("stream_rd_pulses", 64'(rd_pulses), 64'd8);
        if (log_t.size() >= 32) check("stream_span", 64'(log_t[31] - log_t[0]), 64'd31);
        for (int n = 0; n < 32 && n < log_d.size(); n++)
            check("stream_data", 64'(log_d[n]), 64'(16'h5000 + 16'(n)));

        // Backpressure: ready pattern 1,0,0,1
        clear_log();
        for (int w = 0; w < 4; w++) push(0, mkword(16'h6000 + 16'(4 * w)));
        for (int k = 0; k < 200 && log_d.size() < 16; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        out_ready = 1'b1;
        wait_beats("bp", 16, 20);
        repeat (4) tick();
        check("bp_beats", 64'(log_d.size()), 64'd16);
        for (int n = 0; n < 16 && n < log_d.size(); n++)
            check("bp_data", 64'(log_d[n]), 64'(16'h6000 + 16'(n)));

        // Flush with lane=1, nxt staged, no read pending
        clear_log();
        out_ready = 1'b0;
        push(0, mkword(16'h7000));
        push(0, mkword(16'h7100));
        repeat (8) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("fl_pre_beats", 64'(log_d.size()), 64'd1);
        if (log_d.size() >= 1) check("fl_pre_data", 64'(log_d[0]), 64'h7000);
        check("fl_pre_cnt", 64'(beat_cnt), 64'd1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_cnt", 64'(beat_cnt), 64'd0);
        tick();
        clear_log();
        push(0, mkword(16'h7200));
        out_ready = 1'b1;
        wait_beats("fl_post", 4, 20);
        repeat (6) tick();
        check("fl_post_beats", 64'(log_d.size()), 64'd4);
        for (int n = 0; n < 4 && n < log_d.size(); n++) begin
            check("fl_post_data", 64'(log_d[n]), 64'(16'h7200 + 16'(n)));
            check("fl_post_cnt", 64'(log_c[n]), 64'(n));
        end

        // MSB-first, second word arrives during the last-lane handshake
        push(1, 64'hAAAA_BBBB_CCCC_DDDD);
        @(negedge clk);
        check("msb_rd_en", 64'(rd_en[1]), 64'd1);
        tick();
        tick();
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("msb_valid", 64'(v1), 64'd1);
            check("msb_data", 64'(d1), 64'(msb_exp[j]));
            check("msb_last", 64'(l1), 64'd1);
            check("msb_cnt", 64'(c1), 64'd0);
            tick();
            if (j == 1) push(1, 64'h1111_2222_3333_4444);
        end
        @(negedge clk);
        check("msb_valid_end", 64'(v1), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_rd_unpack.md
Name: fifo_rd_unpack

Overview:
- Read-side consumer for the 64-bit output port of the design's width-converting async FIFOs; runs entirely in the FIFO read clock domain.
- Pops 64-bit words from the FIFO's non-FWFT read port and serialises each word into RATIO narrow beats on a valid/ready stream.
- Keeps one word in flight plus one staged word, so it sustains one beat per clock while the FIFO is non-empty.
- Asserts out_last every BURST_BEATS beats, for line- or burst-framed consumers such as the video or DDR write paths.

Parameters:
- IN_W, 64, FIFO read data width.
- OUT_W, 16, output beat width; IN_W must be an integer multiple of OUT_W.
- RATIO, IN_W/OUT_W (derived localparam), number of beats per word.
- LSB_FIRST, 1, 1 emits bits [OUT_W-1:0] first; 0 emits the MSB lane first.
- BURST_BEATS, 1024, beats per burst for out_last generation; must be at least 1.
- CNT_W, 16, width of beat_cnt.

Ports:
- clk  in  1  read-domain clock; the same clock as the FIFO rd_clk.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous drop of all buffered data and restart of framing.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  IN_W  FIFO read data, valid one clk after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty flag.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  OUT_W  beat data.
- out_last  out  1  last beat of the current burst.
- beat_cnt  out  CNT_W  position of the current beat within the burst, 0..BURST_BEATS-1.

Behaviour:
- Reset: while rst_n is sampled low at the clk edge, every output is 0 and all internal state clears (cur_v, nxt_v, pend, lane, beat counter).
- Storage is three elements:
  - cur, the word being serialised, with lane index 0..RATIO-1.
  - nxt, the staged word.
  - pend, a flag meaning a read was issued last cycle.
- Read request: fifo_rd_en = !fifo_rd_empty && !pend && !nxt_v && !flush. This is combinational from registered state, and at most one read is outstanding.
- Data capture: on the cycle after fifo_rd_en, the word is written to cur if cur is empty, or is being vacated this same cycle. Otherwise it is written to nxt.
- Output:
  - out_valid = cur_v.
  - out_data is the lane selected by lane index; with LSB_FIRST=1, lane k = cur[k*OUT_W +: OUT_W].
  - out_data, out_last and beat_cnt are held stable while out_valid=1 and out_ready=0.
- Handshake (out_valid && out_ready):
  - If lane < RATIO-1: lane increments.
  - If lane = RATIO-1: lane returns to 0 and cur is refilled from nxt if nxt_v, else from arriving read data if pend, else cur_v clears.
- Throughput: one beat per clk in steady state. The first beat appears 2 clks after fifo_rd_empty falls.
- Framing:
  - The beat counter advances on each handshake and wraps from BURST_BEATS-1 to 0.
  - out_last = cur_v && (beat counter == BURST_BEATS-1).
  - With BURST_BEATS=1, out_last is high on every beat.
- Empty FIFO: out_valid deasserts after the last lane of the last buffered word. There is no underrun error and framing state is preserved.
- Flush, taking effect at the next edge:
  - cur_v, nxt_v, lane and the beat counter clear.
  - A word already popped (pend=1) is discarded, and pend clears.
  - fifo_rd_en is forced to 0 during flush.
- Reset or flush in the middle of a word discards the remaining lanes. This loss is accepted and is the caller's responsibility.
- Simultaneous events:
  - A last-lane handshake in the same cycle as read data arrival puts the new data in cur with no bubble.
  - Flush has priority over all events.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam helpers: RATIO computation and a clog2 for the lane index width.
  - A typedef for lane_idx_t.
  - A lane_sel function (word, index, LSB_FIRST) that returns OUT_W bits.
- No sub-module is needed. The word buffer, read control and framing counter are all in one module, giving roughly 150–250 lines of RTL.

Test Plan:
- Reset and basic unpack: rst_n held low for 3 clks, then one FIFO word 0x4444_3333_2222_1111 with out_ready=1.
  - Expect fifo_rd_en for 1 clk, out_valid from clk+2, and beats 0x1111, 0x2222, 0x3333, 0x4444 on consecutive clks, then out_valid=0.
- Streaming: FIFO pre-loaded with 8 words, out_ready=1.
  - Expect 32 beats on 32 consecutive clks with no bubbles.
  - fifo_rd_en pulses exactly 8 times, and never while pend=1 or nxt_v=1.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly during a 4-word stream.
  - Expect out_data stable while stalled, no beat lost or duplicated, and fifo_rd_en held low while nxt_v=1.
- Framing: BURST_BEATS=6, 3 words (12 beats).
  - Expect out_last on beats 5 and 11, and beat_cnt sequence 0..5,0..5.
- Flush: flush asserted while lane=1 with nxt_v=1 and pend=0.
  - Expect out_valid=0 on the next clk.
  - The next word read afterwards starts at lane 0 with beat_cnt=0, and no staged data reappears.
- LSB_FIRST=0 with an empty-to-non-empty edge during a last-lane handshake.
  - Word 0xAAAA_BBBB_CCCC_DDDD emits 0xAAAA first.
  - The arriving word enters cur with zero gap cycles.
